// File: rtl/aspiradora_pkg.sv
// aspiradora_pkg: state encoding shared between the vacuum control FSM and its sensor front-end
package aspiradora_pkg;
    typedef enum logic [1:0] {
        off_s       = 2'd0,
        exploring_s = 2'd1,
        cleaning_s  = 2'd2,
        evading_s   = 2'd3
    } state_type;
endpackage

// File: rtl/aspiradora_sensor_ctrl_if.sv
// aspiradora_sensor_ctrl_if: raw sensor inputs, FSM state feedback and request outputs of the front-end
interface aspiradora_sensor_ctrl_if;
    import aspiradora_pkg::*;
    logic      btn_raw;
    logic      dirt_raw;
    logic      obstacle_raw;
    state_type state_0;
    logic      on;
    logic      power_off;
    logic      cleaning;
    logic      evading;
    modport master (
        output btn_raw, dirt_raw, obstacle_raw, state_0,
        input  on, power_off, cleaning, evading
    );
    modport slave (
        input  btn_raw, dirt_raw, obstacle_raw, state_0,
        output on, power_off, cleaning, evading
    );
endinterface

// File: rtl/aspiradora_debounce.sv
// aspiradora_debounce: 2-FF synchronizer followed by a stable-sample counter that flips db
module aspiradora_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);
    localparam int W = $clog2(DEB_CYCLES + 1);
    logic [1:0]   sync;
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (cnt == W'(DEB_CYCLES - 1)) begin
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/aspiradora_sensor_ctrl.sv
// aspiradora_sensor_ctrl: turns debounced button/dirt/obstacle inputs into on/power_off pulses
// and cleaning/evading request levels for the vacuum control FSM
module aspiradora_sensor_ctrl
    import aspiradora_pkg::*;
#(
    parameter int DEB_CYCLES   = 16,
    parameter int CLEAN_HOLD   = 32,
    parameter int EVADE_CYCLES = 64
) (
    input logic clk,
    input logic rst_n,
    aspiradora_sensor_ctrl_if.slave bus
);
    localparam int CW = $clog2(CLEAN_HOLD + 1);
    localparam int EW = $clog2(EVADE_CYCLES + 1);
    localparam logic [1:0] E_IDLE = 2'd0;
    localparam logic [1:0] E_OBST = 2'd1;
    localparam logic [1:0] E_BACK = 2'd2;
    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_DIRT = 2'd1;
    localparam logic [1:0] C_HOLD = 2'd2;
    logic          btn_db, dirt_db, obst_db, btn_q;
    logic          active, btn_rise, kill, e_enter, evade_busy;
    logic [1:0]    e_state, e_next, c_state, c_next;
    logic [EW-1:0] e_timer, e_tnext;
    logic [CW-1:0] c_timer, c_tnext;
    aspiradora_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn  (.clk(clk), .rst_n(rst_n), .raw(bus.btn_raw),      .db(btn_db));
    aspiradora_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dirt (.clk(clk), .rst_n(rst_n), .raw(bus.dirt_raw),     .db(dirt_db));
    aspiradora_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_obst (.clk(clk), .rst_n(rst_n), .raw(bus.obstacle_raw), .db(obst_db));
    assign active     = bus.state_0 != off_s;
    assign btn_rise   = btn_db & ~btn_q;
    // a power-off press or an inactive machine drops every request
    assign kill       = (btn_rise & active) | ~active;
    assign e_enter    = obst_db & active;
    assign evade_busy = (e_state != E_IDLE) | e_enter;
    always_comb begin
        e_next  = e_state;
        e_tnext = e_timer;
        if (kill) begin
            e_next  = E_IDLE;
            e_tnext = '0;
        end else begin
            case (e_state)
                E_IDLE: e_next = e_enter ? E_OBST : E_IDLE;
                E_OBST: begin
                    e_next  = obst_db ? E_OBST : E_BACK;
                    e_tnext = obst_db ? e_timer : EW'(EVADE_CYCLES - 1);
                end
                E_BACK: begin
                    e_next  = obst_db ? E_OBST : (e_timer == '0) ? E_IDLE : E_BACK;
                    e_tnext = (e_timer == '0) ? e_timer : e_timer - 1'b1;
                end
                default: e_next = E_IDLE;
            endcase
        end
    end
    always_comb begin
        c_next  = c_state;
        c_tnext = c_timer;
        if (kill || evade_busy) begin
            c_next  = C_IDLE;
            c_tnext = '0;
        end else begin
            case (c_state)
                C_IDLE: c_next = dirt_db ? C_DIRT : C_IDLE;
                C_DIRT: begin
                    c_next  = dirt_db ? C_DIRT : C_HOLD;
                    c_tnext = dirt_db ? c_timer : CW'(CLEAN_HOLD - 1);
                end
                C_HOLD: begin
                    c_next  = dirt_db ? C_DIRT : (c_timer == '0) ? C_IDLE : C_HOLD;
                    c_tnext = (c_timer == '0) ? c_timer : c_timer - 1'b1;
                end
                default: c_next = C_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q         <= 1'b0;
            e_state       <= E_IDLE;
            e_timer       <= '0;
            c_state       <= C_IDLE;
            c_timer       <= '0;
            bus.on        <= 1'b0;
            bus.power_off <= 1'b0;
            bus.cleaning  <= 1'b0;
            bus.evading   <= 1'b0;
        end else begin
            btn_q         <= btn_db;
            e_state       <= e_next;
            e_timer       <= e_tnext;
            c_state       <= c_next;
            c_timer       <= c_tnext;
            bus.on        <= btn_rise & ~active;
            bus.power_off <= btn_rise & active;
            bus.cleaning  <= c_state != C_IDLE;
            bus.evading   <= e_state != E_IDLE;
        end
    end
endmodule

// File: tb/tb_aspiradora_sensor_ctrl.sv
// tb_aspiradora_sensor_ctrl: directed checks of debounce latency, pulses, request shaping and preemption
module tb_aspiradora_sensor_ctrl;
    import aspiradora_pkg::*;
    localparam int DEB          = 4;
    localparam int CLEAN_HOLD   = 8;
    localparam int EVADE_CYCLES = 10;
    localparam int DB_LAT       = DEB + 2;
    localparam int PULSE_AT     = DB_LAT + 1;
    localparam int LEVEL_RISE   = DB_LAT + 2;
    localparam int CLEAN_FALL   = DB_LAT + 1 + CLEAN_HOLD + 1;
    localparam int EVADE_FALL   = DB_LAT + 1 + EVADE_CYCLES + 1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    aspiradora_sensor_ctrl_if bus ();
    aspiradora_sensor_ctrl #(
        .DEB_CYCLES(DEB), .CLEAN_HOLD(CLEAN_HOLD), .EVADE_CYCLES(EVADE_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_on"}, bus.on, 1'b0);
        chk({tag, "_poff"}, bus.power_off, 1'b0);
        chk({tag, "_clean"}, bus.cleaning, 1'b0);
        chk({tag, "_evade"}, bus.evading, 1'b0);
    endtask
    initial begin
        bus.btn_raw = 1'b0;
        bus.dirt_raw = 1'b0;
        bus.obstacle_raw = 1'b0;
        bus.state_0 = off_s;
        step(3);
        chk_idle("reset");
        rst_n = 1'b1;
        step(2);
        chk_idle("post_reset");
        // button while off -> on pulse only
        bus.btn_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            chk("t1_on", bus.on, k == PULSE_AT);
            chk("t1_poff", bus.power_off, 1'b0);
        end
        bus.btn_raw = 1'b0;
        step(12);
        // button while active -> power_off pulse only
        bus.state_0 = exploring_s;
        bus.btn_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            chk("t1_poff_act", bus.power_off, k == PULSE_AT);
            chk("t1_on_act", bus.on, 1'b0);
        end
        bus.btn_raw = 1'b0;
        step(12);
        // short dirt glitch is rejected
        bus.dirt_raw = 1'b1;
        step(3);
        bus.dirt_raw = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            chk("t2_glitch", bus.cleaning, 1'b0);
        end
        bus.dirt_raw = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            chk("t2_rise", bus.cleaning, k >= LEVEL_RISE);
        end
        bus.dirt_raw = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            step(1);
            chk("t2_hold", bus.cleaning, k < CLEAN_FALL);
        end
        // obstacle drops briefly: evade never lapses, then backs off for EVADE_CYCLES
        bus.obstacle_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk("t3_rise", bus.evading, k >= LEVEL_RISE);
        end
        bus.obstacle_raw = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk("t3_gap", bus.evading, 1'b1);
        end
        bus.obstacle_raw = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step(1);
            chk("t3_again", bus.evading, 1'b1);
        end
        bus.obstacle_raw = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            step(1);
            chk("t3_back", bus.evading, k < EVADE_FALL);
        end
        // evade preempts an active clean
        bus.dirt_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk("t4_clean_up", bus.cleaning, k >= LEVEL_RISE);
        end
        bus.obstacle_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk("t4_clean_drop", bus.cleaning, k < LEVEL_RISE);
            chk("t4_evade_up", bus.evading, k >= LEVEL_RISE);
        end
        bus.dirt_raw = 1'b0;
        bus.obstacle_raw = 1'b0;
        step(30);
        chk_idle("t4_settle");
        // simultaneous dirt and obstacle: clean never asserts
        bus.dirt_raw = 1'b1;
        bus.obstacle_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            chk("t4_both_clean", bus.cleaning, 1'b0);
            chk("t4_both_evade", bus.evading, k >= LEVEL_RISE);
        end
        bus.dirt_raw = 1'b0;
        bus.obstacle_raw = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            step(1);
            chk("t4_both_clean_rel", bus.cleaning, 1'b0);
            chk("t4_both_evade_rel", bus.evading, k < EVADE_FALL);
        end
        // power-off while evading clears the request
        bus.obstacle_raw = 1'b1;
        step(10);
        chk("t5_evading", bus.evading, 1'b1);
        bus.btn_raw = 1'b1;
        for (int k = 1; k <= PULSE_AT; k++) begin
            step(1);
            chk("t5_poff", bus.power_off, k == PULSE_AT);
            chk("t5_evade_hold", bus.evading, 1'b1);
        end
        bus.state_0 = off_s;
        step(1);
        chk("t5_evade_off", bus.evading, 1'b0);
        chk("t5_poff_once", bus.power_off, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            step(1);
            chk("t5_off_ignore", bus.evading, 1'b0);
            chk("t5_off_on", bus.on, 1'b0);
        end
        bus.btn_raw = 1'b0;
        bus.obstacle_raw = 1'b0;
        step(12);
        // asynchronous reset in the middle of the back-off
        bus.state_0 = exploring_s;
        bus.obstacle_raw = 1'b1;
        step(10);
        chk("t6_evading", bus.evading, 1'b1);
        bus.obstacle_raw = 1'b0;
        step(10);
        chk("t6_backing", bus.evading, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("t6_async_rst");
        step(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            chk("t6_after_clean", bus.cleaning, 1'b0);
            chk("t6_after_evade", bus.evading, 1'b0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
